// File: rtl/cdb_arb_pkg.sv
// Shared CDB widths and lane bundle used by the
// arbiter, map table and reservation stations.
package cdb_arb_pkg;

  localparam int CDB_LANES = 6;
  localparam int FU_COUNT  = 8;
  localparam int CDB_PORTS = 6;
  localparam int PR_W      = 7;
  localparam int AR_W      = 5;
  localparam int PTR_W     = 3;
  localparam int CNT_W     = 3;

  typedef logic [PR_W-1:0]  pr_tag_t;
  typedef logic [AR_W-1:0]  ar_tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic    vld;
    pr_tag_t pr;
    ar_tag_t ar;
  } lane_t;

endpackage

// File: rtl/cdb_arb_rr_pick.sv
// Rotating-priority first-K picker: scans from ptr,
// grants up to NUM_LANE requesters, packs lanes low.
module rr_pick
  import cdb_arb_pkg::*;
#(
  parameter int NUM_LANE = CDB_LANES,
  parameter int NUM_REQ  = FU_COUNT
) (
  input  logic [NUM_REQ-1:0]        req_i,
  input  ptr_t                      ptr_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output ptr_t [NUM_LANE-1:0]       idx_o,
  output logic [NUM_LANE-1:0]       vld_o
);

  always_comb begin
    int n;
    int j;
    grant_o = '0;
    idx_o   = '0;
    vld_o   = '0;
    n       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[j] && n < NUM_LANE) begin
        grant_o[j] = 1'b1;
        idx_o[n]   = ptr_t'(j);
        vld_o[n]   = 1'b1;
        n++;
      end
    end
  end

endmodule

// File: rtl/cdb_arb.sv
// CDB arbiter: round-robin completion grant and
// registered broadcast bank for the map table/RS/ROB.
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int CDB_WIDTH = CDB_LANES,
  parameter int NUM_FU    = FU_COUNT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [NUM_FU-1:0]      fu_req,
  input  logic [PR_W*NUM_FU-1:0] fu_pr_tags,
  input  logic [AR_W*NUM_FU-1:0] fu_ar_tags,
  output logic [NUM_FU-1:0]      fu_grant,
  output logic [CDB_WIDTH-1:0]   cdb_broadcast,
  output pr_tag_t                cdb_pr_tag0,
  output pr_tag_t                cdb_pr_tag1,
  output pr_tag_t                cdb_pr_tag2,
  output pr_tag_t                cdb_pr_tag3,
  output pr_tag_t                cdb_pr_tag4,
  output pr_tag_t                cdb_pr_tag5,
  output ar_tag_t                cdb_ar_tag0,
  output ar_tag_t                cdb_ar_tag1,
  output ar_tag_t                cdb_ar_tag2,
  output ar_tag_t                cdb_ar_tag3,
  output ar_tag_t                cdb_ar_tag4,
  output ar_tag_t                cdb_ar_tag5,
  output logic [CNT_W-1:0]       cdb_count
);

  logic [NUM_FU-1:0]    req_eff;
  ptr_t [CDB_WIDTH-1:0] lane_idx;
  logic [CDB_WIDTH-1:0] lane_vld;

  ptr_t                 rr_ptr_q, rr_ptr_d;
  lane_t [CDB_WIDTH-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Flush and reset both suppress every grant this cycle
  assign req_eff = (flush || !reset) ? '0 : fu_req;

  rr_pick #(
    .NUM_LANE (CDB_WIDTH),
    .NUM_REQ  (NUM_FU)
  ) u_pick (
    .req_i   (req_eff),
    .ptr_i   (rr_ptr_q),
    .grant_o (fu_grant),
    .idx_o   (lane_idx),
    .vld_o   (lane_vld)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    lane_d   = '0;
    cnt_d    = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (lane_vld[k]) begin
        lane_d[k].vld = 1'b1;
        lane_d[k].pr  = fu_pr_tags[int'(lane_idx[k])*PR_W +: PR_W];
        lane_d[k].ar  = fu_ar_tags[int'(lane_idx[k])*AR_W +: AR_W];
        cnt_d         = CNT_W'(cnt_d + 1'b1);
        rr_ptr_d      = ptr_t'((int'(lane_idx[k]) + 1) % NUM_FU);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      lane_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
    end
  end

  pr_tag_t lane_pr [CDB_PORTS];
  ar_tag_t lane_ar [CDB_PORTS];

  for (genvar k = 0; k < CDB_PORTS; k++) begin : g_port
    if (k < CDB_WIDTH) begin : g_on
      assign lane_pr[k] = lane_q[k].pr;
      assign lane_ar[k] = lane_q[k].ar;
    end else begin : g_off
      assign lane_pr[k] = '0;
      assign lane_ar[k] = '0;
    end
  end

  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_bc
    assign cdb_broadcast[k] = lane_q[k].vld;
  end

  assign cdb_pr_tag0 = lane_pr[0];
  assign cdb_pr_tag1 = lane_pr[1];
  assign cdb_pr_tag2 = lane_pr[2];
  assign cdb_pr_tag3 = lane_pr[3];
  assign cdb_pr_tag4 = lane_pr[4];
  assign cdb_pr_tag5 = lane_pr[5];
  assign cdb_ar_tag0 = lane_ar[0];
  assign cdb_ar_tag1 = lane_ar[1];
  assign cdb_ar_tag2 = lane_ar[2];
  assign cdb_ar_tag3 = lane_ar[3];
  assign cdb_ar_tag4 = lane_ar[4];
  assign cdb_ar_tag5 = lane_ar[5];
  assign cdb_count   = cnt_q;

endmodule

// File: tb/tb_cdb_arb.sv
// Scoreboard bench for cdb_arb: directed vectors push
// expected grants and lane orders, a monitor compares.
module tb_cdb_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  fu_req = '0;
  logic [55:0] fu_pr_tags;
  logic [39:0] fu_ar_tags;
  logic [7:0]  fu_grant;
  logic [5:0]  cdb_broadcast;
  logic [6:0]  pr0, pr1, pr2, pr3, pr4, pr5;
  logic [4:0]  ar0, ar1, ar2, ar3, ar4, ar5;
  logic [2:0]  cdb_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  gq [$];
  logic [23:0] cq [$];

  logic [6:0] pr_tab [8];
  logic [4:0] ar_tab [8];

  cdb_arb dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .fu_req        (fu_req),
    .fu_pr_tags    (fu_pr_tags),
    .fu_ar_tags    (fu_ar_tags),
    .fu_grant      (fu_grant),
    .cdb_broadcast (cdb_broadcast),
    .cdb_pr_tag0   (pr0),
    .cdb_pr_tag1   (pr1),
    .cdb_pr_tag2   (pr2),
    .cdb_pr_tag3   (pr3),
    .cdb_pr_tag4   (pr4),
    .cdb_pr_tag5   (pr5),
    .cdb_ar_tag0   (ar0),
    .cdb_ar_tag1   (ar1),
    .cdb_ar_tag2   (ar2),
    .cdb_ar_tag3   (ar3),
    .cdb_ar_tag4   (ar4),
    .cdb_ar_tag5   (ar5),
    .cdb_count     (cdb_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // lanes: nibble k = FU on lane k, F = empty lane
  task automatic chk_cdb(input logic [23:0] lanes);
    logic [5:0]  eb;
    logic [41:0] ep;
    logic [29:0] ea;
    logic [2:0]  ec;
    logic [3:0]  n;
    eb = '0; ep = '0; ea = '0; ec = '0;
    for (int k = 0; k < 6; k++) begin
      n = lanes[4*k +: 4];
      if (n != 4'hF) begin
        eb[k]         = 1'b1;
        ep[7*k +: 7]  = pr_tab[n[2:0]];
        ea[5*k +: 5]  = ar_tab[n[2:0]];
        ec            = ec + 3'd1;
      end
    end
    chk("broadcast", 64'(cdb_broadcast), 64'(eb));
    chk("count", 64'(cdb_count), 64'(ec));
    chk("pr_tags", 64'({pr5, pr4, pr3, pr2, pr1, pr0}), 64'(ep));
    chk("ar_tags", 64'({ar5, ar4, ar3, ar2, ar1, ar0}), 64'(ea));
  endtask

  task automatic cyc(input logic rst, input logic fl, input logic [7:0] req,
                     input logic [7:0] eg, input logic [23:0] lanes);
    @(negedge clock);
    #1;
    reset  = rst;
    flush  = fl;
    fu_req = req;
    gq.push_back(eg);
    cq.push_back(lanes);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      #3;
      if (gq.size() > 0) chk("grant", 64'(fu_grant), 64'(gq.pop_front()));
      @(posedge clock);
      #1;
      if (cq.size() > 0) chk_cdb(cq.pop_front());
    end
  end

  initial begin : driver
    pr_tab = '{7'd9, 7'd17, 7'd40, 7'd63, 7'd77, 7'd101, 7'd115, 7'd127};
    ar_tab = '{5'd3, 5'd7, 5'd11, 5'd19, 5'd23, 5'd29, 5'd30, 5'd31};
    for (int i = 0; i < 8; i++) begin
      fu_pr_tags[7*i +: 7] = pr_tab[i];
      fu_ar_tags[5*i +: 5] = ar_tab[i];
    end

    cyc(0, 0, 8'hFF, 8'h00, 24'hFFFFFF);
    cyc(0, 0, 8'hFF, 8'h00, 24'hFFFFFF);
    cyc(1, 0, 8'h05, 8'h05, 24'hFFFF20);
    cyc(1, 0, 8'h00, 8'h00, 24'hFFFFFF);
    cyc(1, 0, 8'h00, 8'h00, 24'hFFFFFF);
    cyc(1, 0, 8'h00, 8'h00, 24'hFFFFFF);
    cyc(1, 0, 8'hFF, 8'hF9, 24'h076543);
    cyc(1, 0, 8'hFF, 8'h7E, 24'h654321);
    cyc(1, 0, 8'h81, 8'h81, 24'hFFFF07);
    cyc(1, 1, 8'h0F, 8'h00, 24'hFFFFFF);
    cyc(1, 0, 8'h0F, 8'h0F, 24'hFF0321);
    cyc(1, 0, 8'h02, 8'h02, 24'hFFFFF1);
    cyc(1, 0, 8'h10, 8'h10, 24'hFFFFF4);
    // pointer is 5 here; reset lands mid-cycle and drops the grant
    cyc(1, 0, 8'hFF, 8'hE7, 24'hFFFFFF);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_grant", 64'(fu_grant), 64'h0);
    chk("rst_bcast", 64'(cdb_broadcast), 64'h0);
    chk("rst_count", 64'(cdb_count), 64'h0);
    chk("rst_pr", 64'({pr5, pr4, pr3, pr2, pr1, pr0}), 64'h0);
    cyc(0, 0, 8'hFF, 8'h00, 24'hFFFFFF);
    cyc(1, 0, 8'hFF, 8'h3F, 24'h543210);
    cyc(1, 0, 8'hFF, 8'hCF, 24'h321076);
    cyc(1, 0, 8'hFF, 8'hF3, 24'h107654);
    cyc(1, 0, 8'h00, 8'h00, 24'hFFFFFF);

    for (int w = 0; w < 20 && (gq.size() > 0 || cq.size() > 0); w++)
      @(posedge clock);
    repeat (2) @(posedge clock);
    if (gq.size() > 0 || cq.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", gq.size() + cq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
